// File: rtl/fdivsqrt_iter_fsm_pkg.sv
// ---------------------------------------------------------------------------
// fdivsqrt_iter_fsm_pkg
//   Shared types for the div/sqrt iterator sequencer:
//   - cvw_t            : configuration subset used by the sequencer
//                        (DURLEN = step-count width, IDIV_ON_FPU = integer
//                        divide shares the FP iterator)
//   - CVW_DEFAULT      : default configuration for standalone elaboration
//   - fdivsqrt_state_t : sequencer state, also used by iterator and
//                        postprocessor assertions
// ---------------------------------------------------------------------------
package fdivsqrt_iter_fsm_pkg;

   typedef struct packed {
      int unsigned DURLEN;
      logic        IDIV_ON_FPU;
   } cvw_t;

   localparam cvw_t CVW_DEFAULT = '{DURLEN: 32'd6, IDIV_ON_FPU: 1'b1};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} fdivsqrt_state_t;

endpackage

// File: rtl/fdivsqrt_iter_fsm_step.sv
// ---------------------------------------------------------------------------
// fdivsqrt_step_counter
//   Load/decrement iteration counter. Saturates at zero so a zero-length
//   request never wraps to the maximum count.
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   dec        : decrement by one when count is non-zero
//   load_val   : value to load
//   count      : current step count
// ---------------------------------------------------------------------------
module fdivsqrt_step_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset)                       count <= '0;
      else if (load)                   count <= load_val;
      else if (dec && (count != '0))   count <= count - W'(1);
   end

endmodule

// File: rtl/fdivsqrt_iter_fsm.sv
// ---------------------------------------------------------------------------
// fdivsqrt_iter_fsm
//   Sequencer for the shared FP div/sqrt and integer divide iterator.
//   Issues the start pulse that loads the preprocessor operand registers,
//   counts iteration steps, and reports busy/done. Handles stall, flush,
//   early termination on zero residual and special-case bypass.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   FDivStartE     : FP div/sqrt request
//   IDivStartE     : integer div/rem request
//   IntDivE        : select integer special-case flag
//   CyclesE        : iteration count from preprocessor
//   ISpecialCaseE  : integer special case (B==0 or |A|<|B|)
//   FSpecialCaseE  : FP special case
//   WZeroE         : residual is zero this step (early termination)
//   StallM         : Memory stage stalled
//   FlushE         : flush Execute
//   IFDivStartE    : start pulse / operand register enable
//   FDivBusyE      : iterator occupied
//   FDivDoneE      : result valid for postprocessor
//   SpecialCaseM   : special-case flag latched at start
// ---------------------------------------------------------------------------
module fdivsqrt_iter_fsm
   import fdivsqrt_iter_fsm_pkg::*;
#(
   parameter cvw_t P = CVW_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  FDivStartE,
   input  logic                  IDivStartE,
   input  logic                  IntDivE,
   input  logic [P.DURLEN-1:0]   CyclesE,
   input  logic                  ISpecialCaseE,
   input  logic                  FSpecialCaseE,
   input  logic                  WZeroE,
   input  logic                  StallM,
   input  logic                  FlushE,
   output logic                  IFDivStartE,
   output logic                  FDivBusyE,
   output logic                  FDivDoneE,
   output logic                  SpecialCaseM
);

   localparam int DURLEN = int'(P.DURLEN);

   fdivsqrt_state_t   state, state_n;
   logic [DURLEN-1:0] step;
   logic              special_case;
   logic              last_step;

   // Integer special case only matters when the int divider shares this path.
   assign special_case = (P.IDIV_ON_FPU && IntDivE) ? ISpecialCaseE : FSpecialCaseE;

   assign IFDivStartE = (FDivStartE | IDivStartE) & (state == IDLE) & ~StallM & ~FlushE;
   assign FDivBusyE   = (state == BUSY) | IFDivStartE;
   assign FDivDoneE   = (state == DONE);

   // step==0 only happens for CyclesE=0, which is run as a single step.
   assign last_step = (step == '0) || (step == DURLEN'(1));

   fdivsqrt_step_counter #(.W(DURLEN)) u_step (
      .clk      (clk),
      .reset    (reset),
      .load     (IFDivStartE),
      .dec      (state == BUSY),
      .load_val (CyclesE),
      .count    (step)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (reset)            SpecialCaseM <= 1'b0;
      else if (IFDivStartE) SpecialCaseM <= special_case;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (IFDivStartE)            state_n = special_case ? DONE : BUSY;
         BUSY: if (last_step || WZeroE)    state_n = DONE;
         DONE: if (!StallM)                state_n = IDLE;
         default:                          state_n = IDLE;
      endcase
      if (FlushE) state_n = IDLE;
   end

endmodule
